// File: rtl/dmem_arb_pkg.sv
// Shared types and port indices for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_LOCK0 = 2'd1,
    ARB_LOCK1 = 2'd2
  } arb_state_t;

  localparam int unsigned PORT_CORE = 0;
  localparam int unsigned PORT_DMA  = 1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Two-port request/response bundle between the requesters and the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32
);
  logic [1:0]                 req_valid_i;
  logic [1:0]                 req_ready_o;
  logic [1:0]                 req_we_i;
  logic [1:0]                 req_lock_i;
  logic [1:0][DM_ADDRESS-1:0] req_addr_i;
  logic [1:0][DATA_W-1:0]     req_wdata_i;
  logic [1:0]                 rsp_valid_o;
  logic [DATA_W-1:0]          rsp_rdata_o;

  modport master (
    output req_valid_i, req_we_i, req_lock_i, req_addr_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_lock_i, req_addr_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o
  );
endinterface

// File: rtl/dmem_rr_pick2.sv
// Two-way combinational grant picker: round robin on last_grant, or port 0 priority
// when DMEM_ARB_FIXED_PRIO_EN is defined.
module dmem_rr_pick2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_c
);

  always_comb begin
    grant_c = 2'b00;
    unique case (valid_i)
      2'b01:   grant_c = 2'b01;
      2'b10:   grant_c = 2'b10;
      2'b11: begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        grant_c = 2'b01;
`else
        grant_c = last_grant_i ? 2'b01 : 2'b10;
`endif
      end
      default: grant_c = 2'b00;
    endcase
  end

  // last_grant is unused in the fixed-priority build
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between core (port 0) and DMA/debug (port 1),
// with watchdog-bounded lock ownership. Option: DMEM_ARB_FIXED_PRIO_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LOCK_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dmem_arbiter_if.slave         req_if,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [DM_ADDRESS-1:0] mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic [DATA_W-1:0]     mem_rdata_i
);

  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_t        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [1:0] valid_c, pick_c, ready_c;
  logic       xfer_c, gnt_port_c, gnt_we_c, gnt_lock_c, force_rel_c;

  assign valid_c = req_if.req_valid_i;

  dmem_rr_pick2 u_pick (
    .valid_i      (valid_c),
    .last_grant_i (last_grant_q),
    .grant_c      (pick_c)
  );

  // Grant: picker in IDLE, lock owner only while locked; nothing issued during reset
  always_comb begin
    ready_c = 2'b00;
    unique case (state_q)
      ARB_IDLE:  ready_c = pick_c;
      ARB_LOCK0: ready_c[PORT_CORE] = valid_c[PORT_CORE];
      ARB_LOCK1: ready_c[PORT_DMA]  = valid_c[PORT_DMA];
      default:   ready_c = 2'b00;
    endcase
    if (!rst_n) ready_c = 2'b00;
  end

  assign xfer_c      = |ready_c;
  assign gnt_port_c  = ready_c[PORT_DMA];
  assign gnt_we_c    = req_if.req_we_i[gnt_port_c];
  assign gnt_lock_c  = req_if.req_lock_i[gnt_port_c];
  assign force_rel_c = (lock_cnt_q == CNT_W'(LOCK_MAX - 1));

  assign mem_read_o  = xfer_c & ~gnt_we_c;
  assign mem_write_o = xfer_c & gnt_we_c;
  assign mem_addr_o  = xfer_c ? req_if.req_addr_i[gnt_port_c]  : '0;
  assign mem_wdata_o = xfer_c ? req_if.req_wdata_i[gnt_port_c] : '0;

  assign req_if.req_ready_o = ready_c;
  assign req_if.rsp_valid_o = rsp_valid_q;
  assign req_if.rsp_rdata_o = rsp_rdata_q;

  // Next state, lock watchdog and response capture
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_cnt_d   = lock_cnt_q;
    rsp_valid_d  = ready_c;
    rsp_rdata_d  = rsp_rdata_q;

    if (xfer_c) begin
      last_grant_d = gnt_port_c;
      rsp_rdata_d  = gnt_we_c ? '0 : mem_rdata_i;
    end

    unique case (state_q)
      ARB_IDLE: begin
        if (xfer_c && gnt_lock_c) begin
          state_d    = gnt_port_c ? ARB_LOCK1 : ARB_LOCK0;
          lock_cnt_d = '0;
        end
      end
      ARB_LOCK0, ARB_LOCK1: begin
        lock_cnt_d = lock_cnt_q + CNT_W'(1);
        if (force_rel_c) begin
          // owner loses the next contention after a watchdog release
          state_d      = ARB_IDLE;
          last_grant_d = (state_q == ARB_LOCK1);
          lock_cnt_d   = '0;
        end else if (xfer_c && !gnt_lock_c) begin
          state_d    = ARB_IDLE;
          lock_cnt_d = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= 1'b1;
      lock_cnt_q   <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_cnt_q   <= lock_cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory (LOCK_MAX=4).
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read, mem_write;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] mem [512];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

  dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .LOCK_MAX(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_if      (bus.slave),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                       input logic [8:0] a0, input logic [8:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    bus.req_valid_i = v;
    bus.req_we_i    = we;
    bus.req_lock_i  = lk;
    bus.req_addr_i  = {a1, a0};
    bus.req_wdata_i = {d1, d0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(2'b01, 2'b01, 2'b00, 9'd3, 9'd0, 32'h11, 32'h0);
    step();
    n_vec++; if (bus.req_ready_o !== 2'b00) begin n_err++; $display("FAIL reset_ready got=%b exp=00", bus.req_ready_o); end
    n_vec++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL reset_mem_write got=%b exp=0", mem_write); end
    rst_n = 1'b1;
    #1;
    n_vec++; if (bus.req_ready_o !== 2'b01) begin n_err++; $display("FAIL post_reset_ready got=%b exp=01", bus.req_ready_o); end
    step();
    n_vec++; if (bus.rsp_valid_o !== 2'b01) begin n_err++; $display("FAIL post_reset_rsp got=%b exp=01", bus.rsp_valid_o); end
    drive(2'b11, 2'b00, 2'b00, 9'd3, 9'd3, 32'h0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (bus.rsp_valid_o !== 2'b00) begin n_err++; $display("FAIL midxfer_rsp_valid got=%b exp=00", bus.rsp_valid_o); end
    n_vec++; if (bus.rsp_rdata_o !== 32'h0) begin n_err++; $display("FAIL midxfer_rsp_rdata got=%h exp=0", bus.rsp_rdata_o); end
    n_vec++; if ({mem_read, mem_write, mem_addr, mem_wdata} !== '0) begin n_err++; $display("FAIL midxfer_mem got=%b%b %h %h exp=all 0", mem_read, mem_write, mem_addr, mem_wdata); end
    step();
    rst_n = 1'b1;
    #1;
    n_vec++; if (bus.req_ready_o !== 2'b01) begin n_err++; $display("FAIL first_grant got=%b exp=01", bus.req_ready_o); end
    step();
    drive(2'b00, 2'b00, 2'b00, 9'd0, 9'd0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_write_read();
    drive(2'b01, 2'b01, 2'b00, 9'd5, 9'd0, 32'hDEADBEEF, 32'h0);
    #1;
    n_vec++; if (bus.req_ready_o !== 2'b01) begin n_err++; $display("FAIL wr_ready got=%b exp=01", bus.req_ready_o); end
    n_vec++; if ({mem_read, mem_write, mem_addr, mem_wdata} !== {1'b0, 1'b1, 9'd5, 32'hDEADBEEF})
      begin n_err++; $display("FAIL wr_mem got=%b%b %h %h exp=01 005 deadbeef", mem_read, mem_write, mem_addr, mem_wdata); end
    step();
    drive(2'b10, 2'b00, 2'b00, 9'd0, 9'd5, 32'h0, 32'h0);
    #1;
    n_vec++; if (bus.req_ready_o !== 2'b10) begin n_err++; $display("FAIL rd_ready got=%b exp=10", bus.req_ready_o); end
    n_vec++; if ({mem_read, mem_write, mem_addr} !== {1'b1, 1'b0, 9'd5}) begin n_err++; $display("FAIL rd_mem got=%b%b %h exp=10 005", mem_read, mem_write, mem_addr); end
    n_vec++; if (bus.rsp_valid_o !== 2'b01 || bus.rsp_rdata_o !== 32'h0) begin n_err++; $display("FAIL wr_ack got=%b %h exp=01 0", bus.rsp_valid_o, bus.rsp_rdata_o); end
    step();
    drive(2'b00, 2'b00, 2'b00, 9'd0, 9'd0, 32'h0, 32'h0);
    #1;
    n_vec++; if (bus.rsp_valid_o !== 2'b10) begin n_err++; $display("FAIL rd_rsp_valid got=%b exp=10", bus.rsp_valid_o); end
    n_vec++; if (bus.rsp_rdata_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_rsp_rdata got=%h exp=deadbeef", bus.rsp_rdata_o); end
    step();
  endtask

  task automatic test_contention();
    logic [1:0] exp_g [4];
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    drive(2'b11, 2'b00, 2'b00, 9'd5, 9'd5, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++; if (bus.req_ready_o !== exp_g[i]) begin n_err++; $display("FAIL contend_%0d got=%b exp=%b", i, bus.req_ready_o, exp_g[i]); end
      if (i > 0) begin
        n_vec++; if (bus.rsp_valid_o !== exp_g[i-1]) begin n_err++; $display("FAIL contend_rsp_%0d got=%b exp=%b", i, bus.rsp_valid_o, exp_g[i-1]); end
      end
      step();
    end
    drive(2'b00, 2'b00, 2'b00, 9'd0, 9'd0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_lock();
    drive(2'b10, 2'b00, 2'b10, 9'd5, 9'd5, 32'h0, 32'h0);
    #1;
    n_vec++; if (bus.req_ready_o !== 2'b10) begin n_err++; $display("FAIL lock_enter got=%b exp=10", bus.req_ready_o); end
    step();
    drive(2'b11, 2'b00, 2'b10, 9'd5, 9'd5, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++; if (bus.req_ready_o !== 2'b10) begin n_err++; $display("FAIL lock_hold_%0d got=%b exp=10", i, bus.req_ready_o); end
      step();
    end
    drive(2'b11, 2'b00, 2'b00, 9'd5, 9'd5, 32'h0, 32'h0);
    #1;
    n_vec++; if (bus.req_ready_o !== 2'b10) begin n_err++; $display("FAIL lock_last got=%b exp=10", bus.req_ready_o); end
    step();
    n_vec++; if (bus.req_ready_o !== 2'b01) begin n_err++; $display("FAIL lock_release got=%b exp=01", bus.req_ready_o); end
    step();
    drive(2'b00, 2'b00, 2'b00, 9'd0, 9'd0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_forced_release();
    logic [1:0] exp_next;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_next = 2'b01;
`else
    exp_next = 2'b10;
`endif
    drive(2'b01, 2'b00, 2'b01, 9'd5, 9'd5, 32'h0, 32'h0);
    #1;
    n_vec++; if (bus.req_ready_o !== 2'b01) begin n_err++; $display("FAIL force_enter got=%b exp=01", bus.req_ready_o); end
    step();
    drive(2'b11, 2'b00, 2'b01, 9'd5, 9'd5, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++; if (bus.req_ready_o !== 2'b01) begin n_err++; $display("FAIL force_hold_%0d got=%b exp=01", i, bus.req_ready_o); end
      step();
    end
    n_vec++; if (bus.req_ready_o !== exp_next) begin n_err++; $display("FAIL force_next got=%b exp=%b", bus.req_ready_o, exp_next); end
    step();
    drive(2'b00, 2'b00, 2'b00, 9'd0, 9'd0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) begin
      n_vec++; if ({mem_read, mem_write} !== 2'b00 || bus.req_ready_o !== 2'b00)
        begin n_err++; $display("FAIL idle_mem_%0d got=%b%b ready=%b exp=00 00", i, mem_read, mem_write, bus.req_ready_o); end
      n_vec++; if (bus.rsp_valid_o !== 2'b00) begin n_err++; $display("FAIL idle_rsp_%0d got=%b exp=00", i, bus.rsp_valid_o); end
      n_vec++; if (bus.rsp_rdata_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL idle_hold_%0d got=%h exp=deadbeef", i, bus.rsp_rdata_o); end
      n_vec++; if (dut.state_q !== ARB_IDLE) begin n_err++; $display("FAIL idle_state_%0d got=%0d exp=%0d", i, dut.state_q, ARB_IDLE); end
      step();
    end
  endtask

  initial begin
    drive(2'b00, 2'b00, 2'b00, 9'd0, 9'd0, 32'h0, 32'h0);
    test_reset();
    test_write_read();
    test_contention();
    test_lock();
    test_forced_release();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
